// File: rtl/mem_stage.sv
// Memory pipeline stage: issues word/byte loads and stores on a handshaked
// data-memory port, stalls upstream while an access is outstanding, and drives writeback.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] rd,
    input  logic              zero_in,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              is_byte,
    input  logic              reg_write,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero_out,
    output logic              misalign_err
);

    typedef enum logic {
        IDLE,
        MEM
    } state_t;

    state_t state_q, state_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_AW-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              zero_out_q, zero_out_d;
    logic              misalign_q, misalign_d;

    // Instruction context captured at accept and retired when the access completes.
    logic [REG_AW-1:0] lat_rd_q, lat_rd_d;
    logic              lat_wr_q, lat_wr_d;
    logic              lat_load_q, lat_load_d;
    logic              lat_byte_q, lat_byte_d;
    logic [1:0]        lat_off_q, lat_off_d;
    logic              lat_zero_q, lat_zero_d;

    logic [7:0]        rd_byte;

    assign rd_byte = mem_rdata[{lat_off_q, 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_en_d     = 1'b0;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        zero_out_d  = zero_out_q;
        misalign_d  = 1'b0;
        lat_rd_d    = lat_rd_q;
        lat_wr_d    = lat_wr_q;
        lat_load_d  = lat_load_q;
        lat_byte_d  = lat_byte_q;
        lat_off_d   = lat_off_q;
        lat_zero_d  = lat_zero_q;

        if (state_q == IDLE) begin
            if (in_valid) begin
                if (!is_load && !is_store) begin
                    wb_en_d    = reg_write && (rd != '0);
                    wb_reg_d   = rd;
                    wb_data_d  = alu_result;
                    zero_out_d = zero_in;
                end else if (!is_byte && (alu_result[1:0] != 2'b00)) begin
                    misalign_d = 1'b1;
                end else begin
                    state_d     = MEM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_store;
                    mem_addr_d  = {alu_result[DATA_W-1:2], 2'b00};
                    mem_be_d    = is_byte ? (4'b0001 << alu_result[1:0]) : 4'b1111;
                    mem_wdata_d = is_byte ? {(DATA_W/8){store_data[7:0]}} : store_data;
                    lat_rd_d    = rd;
                    lat_wr_d    = is_load && reg_write && (rd != '0);
                    lat_load_d  = is_load;
                    lat_byte_d  = is_byte;
                    lat_off_d   = alu_result[1:0];
                    lat_zero_d  = zero_in;
                end
            end
        end else begin
            if (mem_ready) begin
                state_d    = IDLE;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
                zero_out_d = lat_zero_q;
                if (lat_load_q) begin
                    wb_en_d   = lat_wr_q;
                    wb_reg_d  = lat_rd_q;
                    wb_data_d = lat_byte_q ? {{(DATA_W-8){1'b0}}, rd_byte} : mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_en_q     <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            zero_out_q  <= 1'b0;
            misalign_q  <= 1'b0;
            lat_rd_q    <= '0;
            lat_wr_q    <= 1'b0;
            lat_load_q  <= 1'b0;
            lat_byte_q  <= 1'b0;
            lat_off_q   <= '0;
            lat_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_en_q     <= wb_en_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            zero_out_q  <= zero_out_d;
            misalign_q  <= misalign_d;
            lat_rd_q    <= lat_rd_d;
            lat_wr_q    <= lat_wr_d;
            lat_load_q  <= lat_load_d;
            lat_byte_q  <= lat_byte_d;
            lat_off_q   <= lat_off_d;
            lat_zero_q  <= lat_zero_d;
        end
    end

    assign stall        = (state_q == MEM);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_en        = wb_en_q;
    assign wb_reg       = wb_reg_q;
    assign wb_data      = wb_data_q;
    assign zero_out     = zero_out_q;
    assign misalign_err = misalign_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the control/ALU stage.
- Consumes the registered ALU outputs: result/address, store data, destination register and zero flag.
- Performs word/byte loads and stores against a handshaked data-memory port. Stalls upstream while an access is outstanding.
- Produces registered writeback signals for the register file.

Parameters:
- DATA_W, 32, datapath width; also the ALU-result width and the memory address width.
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream stage holds a valid instruction.
- alu_result  input  DATA_W  ALU result; the memory address for loads/stores.
- store_data  input  DATA_W  register B data, written on stores.
- rd  input  REG_AW  destination register.
- zero_in  input  1  ALU zero flag.
- is_load  input  1  instruction is a load.
- is_store  input  1  instruction is a store.
- is_byte  input  1  access is byte-sized; otherwise word-sized.
- reg_write  input  1  instruction writes rd.
- stall  output  1  upstream must hold its outputs; combinational, equals (state==MEM).
- mem_req  output  1  memory request; held until mem_ready.
- mem_we  output  1  write request.
- mem_addr  output  DATA_W  word-aligned address; {alu_result[DATA_W-1:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  DATA_W  write data.
- mem_ready  input  1  access complete; read data is valid in the same cycle.
- mem_rdata  input  DATA_W  read data.
- wb_en  output  1  register-file write enable; one-cycle pulse.
- wb_reg  output  REG_AW  writeback register.
- wb_data  output  DATA_W  writeback data.
- zero_out  output  1  registered zero flag of the last retired instruction.
- misalign_err  output  1  one-cycle pulse on a misaligned word access.

Behaviour:
- Reset: state IDLE. All outputs 0, including mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_*, zero_out and misalign_err. Reset during MEM aborts the access; mem_req is 0 after that edge.
- States:
  - IDLE: accepts an instruction at an edge where in_valid=1.
  - MEM: access outstanding.
- Accept in IDLE, non-memory op (is_load=is_store=0):
  - Next cycle: wb_en=reg_write&&(rd!=0), wb_reg=rd, wb_data=alu_result, zero_out=zero_in.
  - Latency 1; state stays IDLE.
- Accept in IDLE, memory op:
  - Misaligned word access (is_byte=0, alu_result[1:0]!=0): no request issued. Next cycle misalign_err=1 and wb_en=0; state stays IDLE.
  - Otherwise: state→MEM. From the next cycle, mem_req=1 and mem_we=is_store. Address, byte enables and write data are latched and held stable until mem_ready.
- Byte enables:
  - Word access: mem_be=4'b1111.
  - Byte access: mem_be=1<<alu_result[1:0].
- Store data:
  - Word store: mem_wdata=store_data.
  - Byte store: store_data[7:0] replicated to all four lanes.
- In MEM with mem_ready=1 at an edge:
  - state→IDLE and mem_req→0.
  - Load: wb_en=reg_write&&(rd!=0) and wb_reg=latched rd.
    - Word load: wb_data=mem_rdata.
    - Byte load: lane selected by latched addr[1:0], zero-extended.
  - Store: wb_en=0.
  - zero_out=latched zero flag.
- Latency: if mem_ready arrives N cycles after mem_req rises (N≥0), wb_en pulses N+2 cycles after accept. stall is 1 from the cycle after accept until the cycle after mem_ready is sampled, inclusive of the ready cycle.
- Inputs during stall: in_valid and input data are ignored while in MEM; upstream holds them.
- Back-to-back acceptance: the edge that leaves MEM does not accept. A new instruction is accepted at the first IDLE edge after that.
- mem_ready asserted while IDLE: ignored.
- Pulse outputs: wb_en and misalign_err are high for exactly one cycle per event and 0 otherwise. wb_reg and wb_data hold their last values.
- rd==0: writeback is always suppressed (wb_en=0).

Test Plan:
- Reset then non-memory op: alu_result=0x0000_0042, rd=3, reg_write=1 → next cycle wb_en=1, wb_reg=3, wb_data=0x42; stall never rises.
- Word load, addr 0x100, mem_ready 3 cycles after mem_req, mem_rdata=0xDEADBEEF → mem_addr=0x100 and mem_be=4'hF, both held; stall high 4 cycles; then wb_en=1, wb_data=0xDEADBEEF.
- Byte load, addr 0x103, mem_rdata=0xAB00_0000, ready same cycle as req → mem_be=4'b1000; wb_data=0x0000_00AB.
- Byte store, addr 0x201, store_data=0x1234_5677 → mem_we=1, mem_be=4'b0010, mem_wdata=0x7777_7777, mem_addr=0x200; wb_en stays 0.
- Word load at addr 0x102 → no mem_req; misalign_err pulses 1 cycle; wb_en=0.
- Reset asserted while in MEM awaiting ready → next cycle mem_req=0 and stall=0; a later mem_ready is ignored; a following ALU op writes back normally.
